// File: rtl/rstseq_pll.sv
// rstseq_pll: reset sequencer for the 48MHz domain, driven by the PLL lock flag.
// The asynchronous lock flag passes through a SYNC_STAGES flop synchroniser.
// A WAIT_LOCK -> HOLDOFF -> RUN state machine then keeps o_rst high until lock
// has been stable for HOLDOFF_CYCLES cycles. Losing lock re-asserts reset.
// Optional feature macro: RSTSEQ_LOSSCOUNT_EN builds the saturating lock-loss
// counter. When the macro is undefined, o_nLockLoss is tied to zero.
module rstseq_pll #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int LOSSCNT_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pllLocked,
  output logic                 o_rst,
  output logic                 o_running,
  output logic [LOSSCNT_W-1:0] o_nLockLoss
);

  localparam int CNT_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_sync;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rst_q;
  logic                   running_q;

  // Shift the asynchronous lock flag through the synchroniser chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pllLocked};
    end
  end

  assign locked_sync = sync_q[SYNC_STAGES-1];

  // Next-state and holdoff-count logic. Any drop of lock restarts the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_sync) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // State register. Outputs are registered from the next state so they
  // change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      rst_q     <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_q     <= (state_d != RUN);
      running_q <= (state_d == RUN);
    end
  end

  assign o_rst     = rst_q;
  assign o_running = running_q;

`ifdef RSTSEQ_LOSSCOUNT_EN
  logic [LOSSCNT_W-1:0] loss_q;

  // Count RUN -> WAIT_LOCK transitions caused by lock loss. Saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && !locked_sync && (loss_q != '1)) begin
      loss_q <= loss_q + LOSSCNT_W'(1);
    end
  end

  assign o_nLockLoss = loss_q;
`else
  assign o_nLockLoss = '0;
`endif

endmodule

// File: tb/tb_rstseq_pll.sv
// tb_rstseq_pll: randomized and directed bench for rstseq_pll.
// The bench instantiates two copies of the design on the same stimulus:
// one with default parameters and one with LOSSCNT_W=2 to exercise saturation.
// A reference model tracks the expected outputs. It treats the synchroniser as
// a sample delay line and tracks the length of the current run of lock samples
// seen by the state machine.
module tb_rstseq_pll;

  localparam int SYNC_STAGES    = 2;
  localparam int HOLDOFF_CYCLES = 16;
  localparam int RELEASE_EDGES  = SYNC_STAGES + HOLDOFF_CYCLES + 1;
  localparam int ASSERT_EDGES   = SYNC_STAGES + 1;
`ifdef RSTSEQ_LOSSCOUNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  // Clock and DUT signals.
  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_lock = 1'b0;
  logic       rst_a, run_a, rst_b, run_b;
  logic [7:0] loss_a;
  logic [1:0] loss_b;

  always #5 clk = ~clk;

  rstseq_pll dut (
    .i_clk(clk), .i_rst(i_rst), .i_pllLocked(i_lock),
    .o_rst(rst_a), .o_running(run_a), .o_nLockLoss(loss_a)
  );

  rstseq_pll #(.LOSSCNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(i_rst), .i_pllLocked(i_lock),
    .o_rst(rst_b), .o_running(run_b), .o_nLockLoss(loss_b)
  );

  // Scoreboard state.
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit pipe_q[$];
  int run_len     = 0;
  bit exp_running = 1'b0;
  int exp_loss8   = 0;
  int exp_loss2   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge.
  // lockedSync is the input sample taken SYNC_STAGES edges earlier, or 0 after reset.
  // Release needs HOLDOFF_CYCLES+1 consecutive high samples: one to leave
  // WAIT_LOCK, then HOLDOFF_CYCLES more in holdoff.
  task automatic model_edge(input bit rst, input bit lock);
    bit seen;
    if (rst) begin
      pipe_q.delete();
      for (int i = 0; i < SYNC_STAGES; i++) pipe_q.push_back(1'b0);
      run_len     = 0;
      exp_running = 1'b0;
      exp_loss8   = 0;
      exp_loss2   = 0;
    end else begin
      seen = pipe_q.pop_front();
      pipe_q.push_back(lock);
      if (seen) begin
        if (run_len < 100000) run_len++;
      end else begin
        if (exp_running) begin
          if (exp_loss8 < 255) exp_loss8++;
          if (exp_loss2 < 3) exp_loss2++;
        end
        run_len = 0;
      end
      exp_running = (run_len >= HOLDOFF_CYCLES + 1);
    end
  endtask

  // Driver: apply inputs, take one edge, update the model, then check all outputs.
  task automatic step(input bit rst, input bit lock);
    i_rst  = rst;
    i_lock = lock;
    @(posedge clk);
    model_edge(rst, lock);
    #1;
    check("rst", rst_a, !exp_running);
    check("running", run_a, exp_running);
    check("loss8", loss_a, LOSS_EN ? exp_loss8 : 0);
    check("rst_w2", rst_b, !exp_running);
    check("running_w2", run_b, exp_running);
    check("loss2", loss_b, LOSS_EN ? exp_loss2 : 0);
  endtask

  // Hold the lock input and count edges until o_rst reaches the wanted level.
  // The wait is bounded by a budget.
  task automatic measure(input string tag, input bit lock, input bit want_rst, input int exp_edges);
    int n;
    n = 0;
    do begin
      step(1'b0, lock);
      n++;
    end while ((rst_a !== want_rst) && (n < 60));
    check(tag, n, exp_edges);
  endtask

  initial begin
    // Reset held for 3 edges with lock high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Clean lock: release after exactly 19 edges.
    measure("clean_release", 1'b1, 1'b0, RELEASE_EDGES);
    repeat (4) step(1'b0, 1'b1);

    // Fall back to WAIT_LOCK, then glitch once during holdoff.
    repeat (5) step(1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    measure("glitch_release", 1'b1, 1'b0, RELEASE_EDGES);
    repeat (3) step(1'b0, 1'b1);

    // Loss while running, then relock.
    measure("loss_assert", 1'b0, 1'b1, ASSERT_EDGES);
    step(1'b0, 1'b0);
    measure("relock_release", 1'b1, 1'b0, RELEASE_EDGES);

    // Reset pulse while running with lock held.
    step(1'b1, 1'b1);
    check("midrun_rst", rst_a, 1'b1);
    measure("midrun_release", 1'b1, 1'b0, RELEASE_EDGES);

    // Five losses from RUN; the 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      repeat (HOLDOFF_CYCLES + 6) step(1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0);
      check("sat_seq", loss_b, LOSS_EN ? ((k + 1 > 3) ? 3 : k + 1) : 0);
    end

    // Randomized lock waveforms with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      bit lv;
      lv  = seg[0];
      len = lv ? $urandom_range(1, 30) : $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, lv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
